// File: rtl/sha256_block_core_if.sv
// Block-stream port bundle between the block padder (master) and the SHA-256 compression core (slave).
// blk_data, blk_first and blk_last are valid while blk_valid is high. A block transfers on a clock
// edge where blk_valid and blk_ready are both high. digest, digest_valid and busy are core outputs.
interface sha256_block_core_if;
    logic         blk_valid;
    logic         blk_ready;
    logic [511:0] blk_data;
    logic         blk_first;
    logic         blk_last;
    logic [255:0] digest;
    logic         digest_valid;
    logic         busy;

    modport master (
        output blk_valid, blk_data, blk_first, blk_last,
        input  blk_ready, digest, digest_valid, busy
    );

    modport slave (
        input  blk_valid, blk_data, blk_first, blk_last,
        output blk_ready, digest, digest_valid, busy
    );
endinterface

// File: rtl/sha256_block_core.sv
// Iterative SHA-256 compression core: one round per clock, chaining value kept across blocks.
// Digest updates after every block; digest_valid pulses only after a message's last block.
module sha256_block_core #(
    parameter int ROUNDS = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    sha256_block_core_if.slave   bus,
    output logic [1:0]           dbg_state_o
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ROUND = 2'd1, S_FINAL = 2'd2} state_t;

    localparam logic [255:0] IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

    localparam logic [2047:0] K_ROM = {
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    state_t      state_q, state_d;
    logic [31:0] h_q  [8];
    logic [31:0] h_d  [8];
    logic [31:0] wv_q [8];
    logic [31:0] wv_d [8];
    logic [31:0] w_q  [16];
    logic [31:0] w_d  [16];
    logic [5:0]  t_q, t_d;
    logic        last_q, last_d;
    logic [255:0] digest_q, digest_d;
    logic        dv_q, dv_d;

    logic [31:0] k_t, t1, t2, w_new;

    // One round of the compression function plus the next schedule word (window[0] is W[t]).
    always_comb begin
        k_t = K_ROM[2047 - 32 * int'(t_q) -: 32];
        t1  = wv_q[7] + (rotr(wv_q[4], 6) ^ rotr(wv_q[4], 11) ^ rotr(wv_q[4], 25))
            + ((wv_q[4] & wv_q[5]) ^ (~wv_q[4] & wv_q[6])) + k_t + w_q[0];
        t2  = (rotr(wv_q[0], 2) ^ rotr(wv_q[0], 13) ^ rotr(wv_q[0], 22))
            + ((wv_q[0] & wv_q[1]) ^ (wv_q[0] & wv_q[2]) ^ (wv_q[1] & wv_q[2]));
        w_new = (rotr(w_q[14], 17) ^ rotr(w_q[14], 19) ^ (w_q[14] >> 10)) + w_q[9]
              + (rotr(w_q[1], 7) ^ rotr(w_q[1], 18) ^ (w_q[1] >> 3)) + w_q[0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            for (int i = 0; i < 8; i++) begin
                h_q[i]  <= IV[255 - 32 * i -: 32];
                wv_q[i] <= '0;
            end
            for (int i = 0; i < 16; i++) w_q[i] <= '0;
            t_q      <= '0;
            last_q   <= 1'b0;
            digest_q <= '0;
            dv_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            h_q      <= h_d;
            wv_q     <= wv_d;
            w_q      <= w_d;
            t_q      <= t_d;
            last_q   <= last_d;
            digest_q <= digest_d;
            dv_q     <= dv_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.blk_valid) state_d = S_ROUND;
            S_ROUND: if (t_q == 6'(ROUNDS - 1)) state_d = S_FINAL;
            S_FINAL: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        h_d      = h_q;
        wv_d     = wv_q;
        w_d      = w_q;
        t_d      = t_q;
        last_d   = last_q;
        digest_d = digest_q;
        dv_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.blk_valid) begin
                    for (int i = 0; i < 16; i++) w_d[i] = bus.blk_data[511 - 32 * i -: 32];
                    t_d    = '0;
                    last_d = bus.blk_last;
                    for (int i = 0; i < 8; i++) begin
                        if (bus.blk_first) begin
                            h_d[i]  = IV[255 - 32 * i -: 32];
                            wv_d[i] = IV[255 - 32 * i -: 32];
                        end else begin
                            wv_d[i] = h_q[i];
                        end
                    end
                end
            end
            S_ROUND: begin
                wv_d[0] = t1 + t2;
                wv_d[1] = wv_q[0];
                wv_d[2] = wv_q[1];
                wv_d[3] = wv_q[2];
                wv_d[4] = wv_q[3] + t1;
                wv_d[5] = wv_q[4];
                wv_d[6] = wv_q[5];
                wv_d[7] = wv_q[6];
                for (int i = 0; i < 15; i++) w_d[i] = w_q[i + 1];
                w_d[15] = w_new;
                t_d     = t_q + 6'd1;
            end
            S_FINAL: begin
                for (int i = 0; i < 8; i++) begin
                    h_d[i] = h_q[i] + wv_q[i];
                    digest_d[255 - 32 * i -: 32] = h_q[i] + wv_q[i];
                end
                dv_d = last_q;
            end
            default: ;
        endcase
    end

    always_comb begin
        bus.blk_ready    = (state_q == S_IDLE);
        bus.busy         = (state_q != S_IDLE);
        bus.digest       = digest_q;
        bus.digest_valid = dv_q;
        dbg_state_o      = state_q;
    end
endmodule

// File: tb/tb_sha256_block_core.sv
// Randomized and known-answer bench for sha256_block_core against a full-array SHA-256 model.
module tb_sha256_block_core;
  localparam int ROUNDS = 64;
  localparam logic [255:0] IV = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] ABC_D   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] EMPTY_D = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] BTC1_D  = 256'hb9d751533593ac10cdfb7b8e03cad8babc67d8eaeac0a3699b82857dacac9390;
  localparam logic [255:0] BTC2_D  = 256'h1dbd981fe6985776b644b173a4d0385ddc1aa2a829688d1e0000000000000000;

  logic clk;
  logic rst;
  logic [1:0] dbg_state;
  sha256_block_core_if bus ();

  sha256_block_core #(.ROUNDS(ROUNDS)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .dbg_state_o(dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // reference model
  logic [31:0] k_tab [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] v [8];
    logic [31:0] t1, t2;
    logic [255:0] hout;
    for (int i = 0; i < 16; i++) w[i] = blk[511 - 32 * i -: 32];
    for (int i = 16; i < 64; i++)
      w[i] = (ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7]
           + (ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
    for (int i = 0; i < 8; i++) v[i] = hin[255 - 32 * i -: 32];
    for (int t = 0; t < 64; t++) begin
      t1 = v[7] + (ror(v[4], 6) ^ ror(v[4], 11) ^ ror(v[4], 25)) + ((v[4] & v[5]) ^ (~v[4] & v[6]))
         + k_tab[t] + w[t];
      t2 = (ror(v[0], 2) ^ ror(v[0], 13) ^ ror(v[0], 22)) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int j = 7; j > 0; j--) v[j] = v[j-1];
      v[4] = v[4] + t1;
      v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) hout[255 - 32 * i -: 32] = hin[255 - 32 * i -: 32] + v[i];
    return hout;
  endfunction

  // scoreboard
  logic [255:0] exp_q[$];
  int           acc_q[$];
  logic [255:0] model_h = IV;
  logic [255:0] last_digest = '0;
  int errors = 0;
  int n_checks = 0;
  int dv_cnt = 0;
  logic prev_dv = 1'b0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && bus.digest_valid) begin
      dv_cnt++;
      last_digest = bus.digest;
      check("dv_pulse_width", 256'(prev_dv), 256'(0));
      if (exp_q.size() == 0) begin
        check("dv_spurious", 256'(1), 256'(0));
      end else begin
        check("digest_model", bus.digest, exp_q.pop_front());
        check("dv_latency", 256'(cyc - acc_q.pop_front()), 256'(ROUNDS + 1));
      end
    end
    prev_dv = bus.digest_valid;
  end

  // driver tasks
  task automatic send_block(input logic [511:0] d, input bit first, input bit last, input bit keep,
                            output int waits, output int acc);
    waits = 0;
    acc = 0;
    @(negedge clk);
    bus.blk_valid = 1'b1;
    bus.blk_data  = d;
    bus.blk_first = first;
    bus.blk_last  = last;
    while (!bus.blk_ready && waits < 300) begin
      @(negedge clk);
      waits++;
    end
    if (waits >= 300) begin
      check("send_timeout", 256'(0), 256'(1));
      bus.blk_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      acc = cyc;
      if (!keep) bus.blk_valid = 1'b0;
      if (first) model_h = IV;
      model_h = compress(model_h, d);
      if (last) begin
        exp_q.push_back(model_h);
        acc_q.push_back(acc);
      end
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while ((bus.busy || !bus.blk_ready) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) check("idle_timeout", 256'(0), 256'(1));
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    acc_q.delete();
    model_h = IV;
  endtask

  logic [511:0] abc_blk, empty_blk, btc_b1, btc_b2, dbl_blk, rnd_blk;
  int w0, w1, a0, a1, dv0;

  initial begin
    abc_blk   = {32'h61626380, 448'h0, 32'h00000018};
    empty_blk = {32'h80000000, 480'h0};
    btc_b1 = {32'h01000000, 32'h81cd02ab, 32'h7e569e8b, 32'hcd9317e2, 32'hfe99f2de, 32'h44d49ab2,
              32'hb8851ba4, 32'ha3080000, 32'h00000000, 32'he320b6c2, 32'hfffc8d75, 32'h0423db8b,
              32'h1eb942ae, 32'h710e951e, 32'hd797f7af, 32'hfc8892b0};
    btc_b2 = {32'hf1fc122b, 32'hc7f5d74d, 32'hf2b9441a, 32'h42a14695, 32'h80000000, 320'h0, 32'h00000280};
    dbl_blk = {BTC1_D, 32'h80000000, 192'h0, 32'h00000100};

    rst = 1'b1;
    bus.blk_valid = 1'b0;
    bus.blk_data  = '0;
    bus.blk_first = 1'b0;
    bus.blk_last  = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", 256'(bus.blk_ready), 256'(1));
    check("rst_busy", 256'(bus.busy), 256'(0));
    check("rst_digest", bus.digest, 256'(0));
    check("rst_dv", 256'(bus.digest_valid), 256'(0));
    check("rst_state", 256'(dbg_state), 256'(0));

    // known answers: abc, empty
    send_block(abc_blk, 1'b1, 1'b1, 1'b0, w0, a0);
    wait_idle();
    check("abc_kat", last_digest, ABC_D);
    send_block(empty_blk, 1'b1, 1'b1, 1'b0, w0, a0);
    wait_idle();
    check("empty_kat", last_digest, EMPTY_D);

    // bitcoin header: two blocks, then the double hash
    dv0 = dv_cnt;
    send_block(btc_b1, 1'b1, 1'b0, 1'b0, w0, a0);
    wait_idle();
    check("btc_no_dv_b1", 256'(dv_cnt - dv0), 256'(0));
    send_block(btc_b2, 1'b0, 1'b1, 1'b0, w0, a0);
    wait_idle();
    check("btc_dv_b2", 256'(dv_cnt - dv0), 256'(1));
    check("btc_first_hash", last_digest, BTC1_D);
    send_block(dbl_blk, 1'b1, 1'b1, 1'b0, w0, a0);
    wait_idle();
    check("btc_double_hash", last_digest, BTC2_D);

    // backpressure: second block held valid throughout the first
    send_block(abc_blk, 1'b1, 1'b1, 1'b1, w0, a0);
    send_block(empty_blk, 1'b1, 1'b1, 1'b0, w1, a1);
    check("bp_ready_low_cycles", 256'(w1), 256'(ROUNDS + 1));
    check("bp_accept_spacing", 256'(a1 - a0), 256'(ROUNDS + 2));
    wait_idle();
    check("bp_second_digest", last_digest, EMPTY_D);

    // reset mid-round, then a first=0 block must chain from the IV
    send_block(abc_blk, 1'b1, 1'b1, 1'b0, w0, a0);
    repeat (30) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    acc_q.delete();
    model_h = IV;
    check("midrst_ready", 256'(bus.blk_ready), 256'(1));
    check("midrst_busy", 256'(bus.busy), 256'(0));
    check("midrst_digest", bus.digest, 256'(0));
    send_block(empty_blk, 1'b0, 1'b1, 1'b0, w0, a0);
    wait_idle();
    check("midrst_empty", last_digest, EMPTY_D);

    // chaining: abc (not last) then empty with first=0
    dv0 = dv_cnt;
    send_block(abc_blk, 1'b1, 1'b0, 1'b0, w0, a0);
    wait_idle();
    check("chain_mid_digest", bus.digest, compress(IV, abc_blk));
    send_block(empty_blk, 1'b0, 1'b1, 1'b0, w0, a0);
    wait_idle();
    check("chain_dv_count", 256'(dv_cnt - dv0), 256'(1));
    check("chain_digest", last_digest, compress(compress(IV, abc_blk), empty_blk));

    // randomized messages
    for (int m = 0; m < 8; m++) begin
      int nblk;
      nblk = $urandom_range(1, 3);
      for (int b = 0; b < nblk; b++) begin
        bit f, l, k;
        for (int j = 0; j < 16; j++) rnd_blk[511 - 32 * j -: 32] = $urandom;
        f = (b == 0) ? ($urandom_range(0, 3) != 0) : 1'b0;
        l = (b == nblk - 1);
        k = !l && ($urandom_range(0, 1) == 1);
        send_block(rnd_blk, f, l, k, w0, a0);
        if (!k) repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      wait_idle();
      check("rand_final_digest", bus.digest, model_h);
    end

    check("pending_empty", 256'(exp_q.size()), 256'(0));
    $display("Result: errors=%0d of %0d checks", errors, n_checks);
    $finish;
  end
endmodule

// File: doc/sha256_block_core.md
Name: sha256_block_core

Overview:
- Iterative SHA-256 compression engine; consumes padded 512-bit message blocks and produces the 256-bit digest, one round per clock.
- Sits downstream of the header padder; it is the consumer end of the padder's block stream.
- For Bitcoin double hashing, the miner controller feeds it 2 header blocks, then 1 padded digest block.

Parameters:
- ROUNDS, 64, number of compression rounds per block. 64 is compliant; lower values are for reduced-round debug only. Legal range 16..64.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset.
- blk_valid  input  1  blk_data/blk_first/blk_last are valid.
- blk_ready  output  1  core can accept a block this cycle.
- blk_data  input  512  message block, big-endian: W0 = blk_data[511:480], W15 = blk_data[31:0].
- blk_first  input  1  block starts a new message; chaining value is reloaded with the IV.
- blk_last  input  1  block ends the message; digest_valid pulses after it.
- digest  output  256  chaining value H0..H7, H0 in [255:224]; registered.
- digest_valid  output  1  one-cycle pulse; digest is final for the message.
- busy  output  1  high while compressing (the ROUND or FINAL state).

Behaviour:
- Reset (rst=1 at a clk edge, from any state, including mid-round) forces:
  - state IDLE, blk_ready=1, busy=0, digest_valid=0, digest=0;
  - chaining registers H = IV (6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19);
  - the in-flight block is discarded.
- States: IDLE, ROUND, FINAL.
- IDLE:
  - blk_ready=1.
  - On blk_valid & blk_ready: latch the 16 words into the schedule window; set round counter t=0; latch blk_last.
  - Working vars a..h load from IV if blk_first=1, else from current H. If blk_first=1, H also loads the IV.
  - Go to ROUND.
- ROUND:
  - blk_ready=0; blk_valid is ignored.
  - Each cycle performs one round: T1 = h + S1(e) + Ch(e,f,g) + K[t] + W[t]; T2 = S0(a) + Maj(a,b,c).
  - Standard register shift; all additions mod 2^32.
  - W[t] is window[0]. The window shifts by one word per cycle; the new entry is s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16], mod 2^32.
  - K is a 64-entry constant ROM (FIPS 180-4).
  - After the round with t = ROUNDS-1, go to FINAL.
- FINAL (one cycle):
  - Hi += working var i, mod 2^32, for all 8 words; digest is updated from the new H.
  - If the latched blk_last=1, digest_valid=1 in the cycle after the FINAL edge.
  - Go to IDLE.
- Latency:
  - Block accepted at edge N. Rounds occur on edges N+1..N+ROUNDS; FINAL at edge N+ROUNDS+1.
  - digest and digest_valid are visible after edge N+ROUNDS+1, i.e. N+65 for ROUNDS=64.
  - blk_ready returns high in that same cycle.
- Throughput: one block per ROUNDS+2 cycles. A back-to-back block is accepted in the cycle digest_valid is high.
- Between messages, digest holds its last value. It updates after every block, including non-last blocks, but digest_valid pulses only for last blocks.
- blk_first=1 and blk_last=1 together form a single-block message (the second hash of a double SHA).
- blk_first=0 on the first block after reset chains from the IV, because reset loads H with the IV.
- No output byte reversal. The Bitcoin display order is the controller's concern.

Test Plan:
- Single-block message "abc": block 61626380 followed by 14 zero words, then 00000018; first=last=1 → digest_valid exactly at N+65, digest = ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad.
- Empty message: block 80000000 followed by 15 zero words; first=last=1 → e3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855.
- Bitcoin block 125552 header (80 bytes, padded to 2 blocks, length 0x280):
  - no digest_valid pulse after block 1; the pulse comes after block 2;
  - digest = b9d751533593ac10cdfb7b8e03cad8babc67d8eaeac0a3699b82857dacac9390;
  - re-hashing that digest as one padded block → 1dbd981fe6985776b644b173a4d0385ddc1aa2a829688d1e0000000000000000.
- Backpressure: hold blk_valid=1 with a second block throughout busy → blk_ready=0 for 65 cycles; the second block is accepted exactly in the digest_valid cycle; both digests are correct.
- Reset mid-operation: assert rst at round 30 of "abc" → next cycle blk_ready=1, busy=0, digest=0; re-sending the "empty" block gives the empty-message digest, with no stale chaining.
- Chaining: send the "abc" block with last=0, then the empty-message block with first=0, last=1 → exactly one digest_valid pulse, at the end of the second block. Digest matches a software model chaining from the "abc" H.
